// File: rtl/arbt_pkg.sv
// Shared types and helpers for the grant-driven transfer stage.
// Latency: n/a (types and combinational helper only).
// Backpressure: n/a.
package arbt_pkg;

    localparam int NUM_SRC = 4;
    localparam int SRC_W   = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        GAP  = 2'd2
    } state_t;

    typedef struct packed {
        logic             vld;    // exactly one bit set
        logic             multi;  // more than one bit set
        logic [SRC_W-1:0] idx;
    } onehot_t;

    function automatic onehot_t onehot_to_idx(input logic [NUM_SRC-1:0] v);
        onehot_t r;
        int      n;
        r = '0;
        n = 0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (v[i]) begin
                r.idx = SRC_W'(i);
                n++;
            end
        end
        r.vld   = (n == 1);
        r.multi = (n > 1);
        return r;
    endfunction

endpackage

// File: rtl/xfer_out_reg.sv
// Registered valid/ready output stage carrying data, last flag and source index.
// Latency: one cycle from load to m_vld.
// Backpressure: ld_rdy = ~m_vld | m_rdy, so a held beat blocks new loads.
module xfer_out_reg #(
    parameter int DW    = 32,
    parameter int SRC_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld,
    input  logic [DW-1:0]    ld_data,
    input  logic             ld_last,
    input  logic [SRC_W-1:0] ld_src,
    output logic             ld_rdy,
    output logic             m_vld,
    output logic [DW-1:0]    m_data,
    output logic             m_last,
    output logic [SRC_W-1:0] m_src,
    input  logic             m_rdy
);

    assign ld_rdy = ~m_vld | m_rdy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_vld  <= 1'b0;
            m_data <= '0;
            m_last <= 1'b0;
            m_src  <= '0;
        end else if (ld) begin
            m_vld  <= 1'b1;
            m_data <= ld_data;
            m_last <= ld_last;
            m_src  <= ld_src;
        end else if (m_rdy) begin
            m_vld  <= 1'b0;
        end
    end

endmodule

// File: rtl/gnt_xfer_mux.sv
// Locks onto the arbiter-granted source and forwards its burst until last or the beat cap.
// Latency: grant -> XFER next cycle; each accepted beat appears on m_vld one cycle later.
// Backpressure: src_rdy[sel] follows output-register space; later grants are ignored while busy.
module gnt_xfer_mux
    import arbt_pkg::*;
#(
    parameter int DW        = 32,
    parameter int BURST_MAX = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_SRC-1:0]   src_vld,
    input  logic [NUM_SRC*DW-1:0] src_data,
    input  logic [NUM_SRC-1:0]   src_last,
    output logic [NUM_SRC-1:0]   src_rdy,
    output logic [NUM_SRC-1:0]   req,
    input  logic [NUM_SRC-1:0]   gnt,
    output logic                 m_vld,
    output logic [DW-1:0]        m_data,
    output logic                 m_last,
    output logic [SRC_W-1:0]     m_src,
    input  logic                 m_rdy,
    output logic                 busy,
    output logic                 err
);

    localparam int CNT_W = $clog2(BURST_MAX + 1);

    state_t           state, state_nxt;
    logic [SRC_W-1:0] sel;
    logic [CNT_W-1:0] beat_cnt;
    onehot_t          gnt_dec;
    logic             space;
    logic             acc;
    logic             fin;
    logic [DW-1:0]    sel_data;

    assign gnt_dec  = onehot_to_idx(gnt);
    assign busy     = (state != IDLE);
    assign req      = src_vld & {NUM_SRC{~busy}};
    assign sel_data = src_data[int'(sel)*DW +: DW];
    assign acc      = (state == XFER) & src_vld[sel] & space;
    // Cap hit on the beat that brings the count to BURST_MAX.
    assign fin      = src_last[sel] | (beat_cnt == CNT_W'(BURST_MAX - 1));

    always_comb begin
        src_rdy = '0;
        if (state == XFER) src_rdy[sel] = space;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (gnt_dec.vld) state_nxt = XFER;
            XFER:    if (acc && fin) state_nxt = GAP;
            GAP:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel      <= '0;
            beat_cnt <= '0;
            err      <= 1'b0;
        end else begin
            err <= (state == IDLE) & gnt_dec.multi;
            if (state == IDLE && gnt_dec.vld) begin
                sel      <= gnt_dec.idx;
                beat_cnt <= '0;
            end else if (acc) begin
                // Wrap on the final beat so the count stays below BURST_MAX.
                beat_cnt <= fin ? '0 : beat_cnt + CNT_W'(1);
            end
        end
    end

    xfer_out_reg #(
        .DW    (DW),
        .SRC_W (SRC_W)
    ) u_out (
        .clk     (clk),
        .rst     (rst),
        .ld      (acc),
        .ld_data (sel_data),
        .ld_last (fin),
        .ld_src  (sel),
        .ld_rdy  (space),
        .m_vld   (m_vld),
        .m_data  (m_data),
        .m_last  (m_last),
        .m_src   (m_src),
        .m_rdy   (m_rdy)
    );

endmodule
